// File: rtl/voter_pkg.sv
// Shared definitions for the ballot decoder: default geometry, FSM state type
// and helpers that derive frame length and ID ranges from the geometry.
package voter_pkg;

    localparam int ID_W_DEF  = 6;
    localparam int NP_N_DEF  = 32;
    localparam int VIP_N_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_RESYNC = 3'd4
    } state_t;

    // start + data + parity + stop
    function automatic int frame_len(input int id_w);
        return id_w + 3;
    endfunction

    function automatic int vip_base(input int np_n);
        return np_n;
    endfunction

    function automatic int vvip_id(input int np_n, input int vip_n);
        return np_n + vip_n;
    endfunction

endpackage

// File: rtl/ballot_id_map.sv
// Combinational decode of a received voter ID into one-hot vote classes,
// flagging IDs above the single VVIP slot as invalid.
module ballot_id_map
    import voter_pkg::*;
#(
    parameter int ID_W  = ID_W_DEF,
    parameter int NP_N  = NP_N_DEF,
    parameter int VIP_N = VIP_N_DEF
) (
    input  logic [ID_W-1:0]  i_id,
    output logic [NP_N-1:0]  o_np,
    output logic [VIP_N-1:0] o_vip,
    output logic             o_vvip,
    output logic             o_invalid
);

    localparam int VIP_BASE = vip_base(NP_N);
    localparam int VVIP_ID  = vvip_id(NP_N, VIP_N);

    logic [31:0] w_id;

    assign w_id = 32'(i_id);

    always_comb begin
        o_np      = '0;
        o_vip     = '0;
        o_vvip    = 1'b0;
        o_invalid = 1'b0;
        for (int k = 0; k < NP_N; k++) begin
            o_np[k] = (w_id == 32'(k));
        end
        for (int k = 0; k < VIP_N; k++) begin
            o_vip[k] = (w_id == 32'(VIP_BASE + k));
        end
        o_vvip    = (w_id == 32'(VVIP_ID));
        o_invalid = (w_id > 32'(VVIP_ID));
    end

endmodule

// File: rtl/ballot_decoder.sv
// Serial ballot frame receiver: deserialises, validates parity/framing/ID/lock
// and emits registered one-cycle vote or error pulses plus saturating counts.
module ballot_decoder
    import voter_pkg::*;
#(
    parameter int ID_W  = ID_W_DEF,
    parameter int NP_N  = NP_N_DEF,
    parameter int VIP_N = VIP_N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             lock,
    output logic [NP_N-1:0]  np,
    output logic [VIP_N-1:0] vip,
    output logic             vvip,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] ballot_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int IDX_W = $clog2(frame_len(ID_W));

    state_t            r_state;
    state_t            w_next;
    logic [IDX_W-1:0]  r_idx;
    logic [ID_W-1:0]   r_id_sr;
    logic              r_par_acc;
    logic              r_par_bad;

    logic [NP_N-1:0]   r_np;
    logic [VIP_N-1:0]  r_vip;
    logic              r_vvip;
    logic              r_err;
    logic [CNT_W-1:0]  r_ballot_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    logic [NP_N-1:0]   w_np;
    logic [VIP_N-1:0]  w_vip;
    logic              w_vvip;
    logic              w_invalid;
    logic              w_at_stop;
    logic              w_accept;
    logic              w_reject;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    ballot_id_map #(
        .ID_W  (ID_W),
        .NP_N  (NP_N),
        .VIP_N (VIP_N)
    ) u_id_map (
        .i_id      (r_id_sr),
        .o_np      (w_np),
        .o_vip     (w_vip),
        .o_vvip    (w_vvip),
        .o_invalid (w_invalid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A 0 seen on the stop bit sends us to RESYNC, so it can never double as a start bit
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (!sin) w_next = ST_DATA;
            ST_DATA:   if (r_idx == IDX_W'(ID_W - 1)) w_next = ST_PARITY;
            ST_PARITY: w_next = ST_STOP;
            ST_STOP:   w_next = sin ? ST_IDLE : ST_RESYNC;
            ST_RESYNC: if (sin) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx     <= '0;
            r_id_sr   <= '0;
            r_par_acc <= 1'b0;
            r_par_bad <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_idx     <= '0;
                    r_par_acc <= 1'b0;
                end
                ST_DATA: begin
                    r_id_sr   <= {r_id_sr[ID_W-2:0], sin};
                    r_par_acc <= r_par_acc ^ sin;
                    r_idx     <= r_idx + IDX_W'(1);
                end
                ST_PARITY: r_par_bad <= r_par_acc ^ sin;
                default: ;
            endcase
        end
    end

    assign w_at_stop = (r_state == ST_STOP);
    assign w_accept  = w_at_stop && sin && !r_par_bad && !w_invalid && !lock;
    assign w_reject  = w_at_stop && !w_accept;

    // Pulses default to 0 every cycle, so each verdict is visible for exactly one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_np         <= '0;
            r_vip        <= '0;
            r_vvip       <= 1'b0;
            r_err        <= 1'b0;
            r_ballot_cnt <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_np   <= w_accept ? w_np : '0;
            r_vip  <= w_accept ? w_vip : '0;
            r_vvip <= w_accept && w_vvip;
            r_err  <= w_reject;
            if (w_accept) r_ballot_cnt <= sat_inc(r_ballot_cnt);
            if (w_reject) r_err_cnt    <= sat_inc(r_err_cnt);
        end
    end

    assign np         = r_np;
    assign vip        = r_vip;
    assign vvip       = r_vvip;
    assign err        = r_err;
    assign busy       = (r_state != ST_IDLE);
    assign ballot_cnt = r_ballot_cnt;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_ballot_decoder.sv
// Randomised, self-checking bench for ballot_decoder against a frame-level outcome model.
module tb_ballot_decoder;

    localparam int ID_W  = 6;
    localparam int NP_N  = 32;
    localparam int VIP_N = 8;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             sin;
    logic             lock;
    logic [NP_N-1:0]  np;
    logic [VIP_N-1:0] vip;
    logic             vvip;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] ballot_cnt;
    logic [CNT_W-1:0] err_cnt;

    typedef struct packed {
        logic [31:0]      cyc;
        logic [NP_N-1:0]  np;
        logic [VIP_N-1:0] vip;
        logic             vvip;
        logic             err;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  exp_ballot = 0;
    int  exp_err = 0;

    ballot_decoder #(
        .ID_W(ID_W), .NP_N(NP_N), .VIP_N(VIP_N), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .sin(sin), .lock(lock),
        .np(np), .vip(vip), .vvip(vvip), .busy(busy), .err(err),
        .ballot_cnt(ballot_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (np != '0 || vip != '0 || vvip || err)
            obs_q.push_back({32'(cyc), np, vip, vvip, err});
    end

    task automatic drive_bit(input logic b, input logic lk);
        @(posedge clk);
        #1;
        sin  = b;
        lock = lk;
    endtask

    // Sends one frame and records the verdict the decoder must give for it.
    task automatic send_frame(input int id, input bit par_bad, input bit stop_bad,
                              input bit lk, input int gap, input int hold);
        logic [ID_W-1:0] idv;
        ev_t e;
        bit reject;
        idv = id[ID_W-1:0];
        drive_bit(1'b0, 1'($urandom_range(0, 1)));
        for (int b = ID_W - 1; b >= 0; b--) drive_bit(idv[b], 1'($urandom_range(0, 1)));
        drive_bit((^idv) ^ par_bad, 1'($urandom_range(0, 1)));
        drive_bit(!stop_bad, lk);
        e = '0;
        e.cyc = 32'(cyc + 1);
        reject = stop_bad || par_bad || lk || (id > NP_N + VIP_N);
        if (reject) begin
            e.err = 1'b1;
            if (exp_err < CMAX) exp_err++;
        end else begin
            if (id < NP_N) e.np[id] = 1'b1;
            else if (id < NP_N + VIP_N) e.vip[id - NP_N] = 1'b1;
            else e.vvip = 1'b1;
            if (exp_ballot < CMAX) exp_ballot++;
        end
        exp_q.push_back(e);
        if (stop_bad) begin
            repeat (hold) drive_bit(1'b0, 1'($urandom_range(0, 1)));
            drive_bit(1'b1, 1'($urandom_range(0, 1)));
        end
        repeat (gap) drive_bit(1'b1, 1'($urandom_range(0, 1)));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) drive_bit(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sin   = 1'b1;
        lock  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({np, vip, vvip, err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got np=%h vip=%h vvip=%b err=%b busy=%b want all 0",
                     np, vip, vvip, err, busy);
        end
        checks++;
        if (ballot_cnt !== '0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_counts got ballot=%0d err=%0d want 0 0", ballot_cnt, err_cnt);
        end
        #1 reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_bit(1'b1, 1'($urandom_range(0, 1)));
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_busy cycle %0d got %b want 0", i, busy);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL idle_pulses got %0d events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_single();
        send_frame(5, 0, 0, 0, 0, 0);
        idle_cycles(3);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (ballot_cnt !== CNT_W'(exp_ballot) || err_cnt !== CNT_W'(exp_err)) begin
            errors++;
            $display("FAIL single_cnt got %0d/%0d want %0d/%0d", ballot_cnt, err_cnt, exp_ballot, exp_err);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        send_frame(33, 0, 0, 0, 0, 0);
        send_frame(40, 0, 0, 0, 0, 0);
        idle_cycles(3);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (ballot_cnt !== CNT_W'(exp_ballot)) begin
            errors++;
            $display("FAIL b2b_cnt got %0d want %0d", ballot_cnt, exp_ballot);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_errors();
        send_frame(7, 1, 0, 0, 0, 0);
        send_frame(63, 0, 0, 0, 0, 0);
        send_frame(3, 0, 1, 0, 0, 5);
        send_frame(3, 0, 0, 0, 0, 0);
        idle_cycles(3);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL err_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL err_ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (ballot_cnt !== CNT_W'(exp_ballot) || err_cnt !== CNT_W'(exp_err)) begin
            errors++;
            $display("FAIL err_cnt got %0d/%0d want %0d/%0d", ballot_cnt, err_cnt, exp_ballot, exp_err);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_lock_reset();
        logic [ID_W-1:0] idv;
        send_frame(2, 0, 0, 1, 0, 0);
        idle_cycles(3);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL lock_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL lock_ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (err_cnt !== CNT_W'(exp_err)) begin
            errors++;
            $display("FAIL lock_errcnt got %0d want %0d", err_cnt, exp_err);
        end
        obs_q.delete();
        exp_q.delete();
        idv = 6'd9;
        drive_bit(1'b0, 1'b0);
        for (int b = ID_W - 1; b >= ID_W - 4; b--) drive_bit(idv[b], 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy got %b want 1", busy);
        end
        #2;
        reset = 1'b0;
        sin   = 1'b1;
        #1;
        checks++;
        if ({np, vip, vvip, err, busy, ballot_cnt, err_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset got busy=%b err=%b ballot=%0d errc=%0d want all 0",
                     busy, err, ballot_cnt, err_cnt);
        end
        exp_ballot = 0;
        exp_err    = 0;
        #3 reset = 1'b1;
        idle_cycles(4);
        checks++;
        if (busy !== 1'b0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_idle got busy=%b events=%0d want 0 0", busy, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            send_frame(int'($urandom_range(0, 63)), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
        idle_cycles(3);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (ballot_cnt !== CNT_W'(exp_ballot) || err_cnt !== CNT_W'(exp_err)) begin
            errors++;
            $display("FAIL rand_cnt got %0d/%0d want %0d/%0d", ballot_cnt, err_cnt, exp_ballot, exp_err);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_saturation();
        int ids[$];
        bit seen[int];
        logic [NP_N-1:0]  v_np;
        logic [VIP_N-1:0] v_vip;
        logic             v_vvip;
        int want_score;
        int got_score;
        for (int i = 0; i < NP_N; i++) ids.push_back(i);
        ids.push_back(33);
        ids.push_back(40);
        want_score = 0;
        foreach (ids[i]) if (!seen.exists(ids[i])) begin
            seen[ids[i]] = 1'b1;
            want_score += (ids[i] < NP_N) ? 1 : (ids[i] < NP_N + VIP_N) ? 4 : 16;
        end
        while (ids.size() < 300) ids.push_back(int'($urandom_range(0, NP_N + VIP_N)));
        foreach (ids[i]) send_frame(ids[i], 0, 0, 0, 0, 0);
        idle_cycles(3);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sat_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL sat_ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (ballot_cnt !== CNT_W'(CMAX) || exp_ballot != CMAX) begin
            errors++;
            $display("FAIL sat_ballot got %0d want %0d", ballot_cnt, CMAX);
        end
        v_np = '0;
        v_vip = '0;
        v_vvip = 1'b0;
        for (int i = 0; i < NP_N + 2 && i < obs_q.size(); i++) begin
            v_np   |= obs_q[i].np;
            v_vip  |= obs_q[i].vip;
            v_vvip |= obs_q[i].vvip;
        end
        got_score = $countones(v_np) + 4 * $countones(v_vip) + 16 * int'(v_vvip);
        checks++;
        if (got_score != want_score) begin
            errors++;
            $display("FAIL voter_score got %0d want %0d", got_score, want_score);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_errors();
        test_lock_reset();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
